// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared constants, FSM state type and helpers for the
// multiply/divide blocks.
//   WIDTH  operand/result width (32)
//   ITER   divider iterations per operation (32)
//   CNT_W  iteration counter width (5)
package multdiv_pkg;
  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;

  // Magnitude computed one bit wider than the operand, so that the magnitude
  // of the most negative value (2^31) is exact.
  function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] ext;
    ext = {x[WIDTH-1], x};
    return x[WIDTH-1] ? -ext : ext;
  endfunction
endpackage

// File: rtl/nr_div32_if.sv
// nr_div32_if: divider request/response bundle.
//   ctrl_DIV        start pulse (master -> slave)
//   data_operandA   signed dividend (master -> slave)
//   data_operandB   signed divisor (master -> slave)
//   data_result     signed quotient (slave -> master)
//   data_exception  divide-by-zero flag (slave -> master)
//   data_resultRDY  one-cycle completion strobe (slave -> master)
//   data_remainder  signed remainder, only with NR_DIV32_REMAINDER_EN
interface nr_div32_if;
  import multdiv_pkg::*;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
`ifdef NR_DIV32_REMAINDER_EN
  logic [WIDTH-1:0] data_remainder;

  modport master (output ctrl_DIV, data_operandA, data_operandB,
                  input  data_result, data_exception, data_resultRDY, data_remainder);
  modport slave  (input  ctrl_DIV, data_operandA, data_operandB,
                  output data_result, data_exception, data_resultRDY, data_remainder);
`else
  modport master (output ctrl_DIV, data_operandA, data_operandB,
                  input  data_result, data_exception, data_resultRDY);
  modport slave  (input  ctrl_DIV, data_operandA, data_operandB,
                  output data_result, data_exception, data_resultRDY);
`endif
endinterface

// File: rtl/nr_div32_step.sv
// nr_div_step: one non-restoring iteration on the 65-bit working register
// {partial remainder[64:32] (signed), quotient[31:0]}.
//   wr_i     current working register
//   b_mag_i  divisor magnitude (33 bits)
//   wr_o     working register after shift, add/sub and quotient bit insert
module nr_div_step
  import multdiv_pkg::*;
(
  input  logic [2*WIDTH:0] wr_i,
  input  logic [WIDTH:0]   b_mag_i,
  output logic [2*WIDTH:0] wr_o
);
  logic [WIDTH:0] rem_sh, rem_new;

  always_comb begin
    // Remainder after the left shift: old bits [63:31]; the old sign bit
    // picks subtract (remainder >= 0) or add (remainder < 0).
    rem_sh  = wr_i[2*WIDTH-1:WIDTH-1];
    rem_new = wr_i[2*WIDTH] ? rem_sh + b_mag_i : rem_sh - b_mag_i;
    wr_o    = {rem_new, wr_i[WIDTH-2:0], ~rem_new[WIDTH]};
  end
endmodule

// File: rtl/nr_div32.sv
// nr_div32: 32-bit signed non-restoring divider, quotient truncated toward 0.
//   clock         rising-edge clock
//   ctrl_reset_n  synchronous active-low reset
//   bus           nr_div32_if.slave: start/operands in, result/flags out
// Latency: start edge 0, data_resultRDY high for one cycle after edge 34
// (after edge 1 for divide-by-zero). A start in any busy state aborts the
// current operation and restarts with the new operands.
// Optional: define NR_DIV32_REMAINDER_EN to add data_remainder (sign of
// dividend) and the remainder correction step.
module nr_div32
  import multdiv_pkg::*;
#(
  parameter int WIDTH = multdiv_pkg::WIDTH
) (
  input  logic       clock,
  input  logic       ctrl_reset_n,
  nr_div32_if.slave  bus
);
  div_state_e       state_q, state_d;
  logic [2*WIDTH:0] wr_q, wr_d, wr_step;
  logic [WIDTH:0]   b_mag_q, b_mag_d;
  logic [WIDTH:0]   a_mag, b_mag_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic [WIDTH-1:0] result_q, result_d, quo;
  logic             exc_q, exc_d, rdy_q, rdy_d;
`ifdef NR_DIV32_REMAINDER_EN
  logic             sgn_rem_q, sgn_rem_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   rem_fix;
`endif

  assign a_mag    = mag(bus.data_operandA);
  assign b_mag_in = mag(bus.data_operandB);
  assign quo      = wr_q[WIDTH-1:0];
`ifdef NR_DIV32_REMAINDER_EN
  // Final non-restoring correction: a negative remainder gets |B| added back.
  assign rem_fix  = wr_q[2*WIDTH] ? wr_q[2*WIDTH:WIDTH] + b_mag_q : wr_q[2*WIDTH:WIDTH];
`endif

  nr_div_step u_step (.wr_i(wr_q), .b_mag_i(b_mag_q), .wr_o(wr_step));

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    b_mag_d   = b_mag_q;
    cnt_d     = cnt_q;
    sgn_quo_d = sgn_quo_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
`ifdef NR_DIV32_REMAINDER_EN
    sgn_rem_d = sgn_rem_q;
    rem_d     = rem_q;
`endif
    if (bus.ctrl_DIV) begin
      // Capture (also abort-and-restart when busy); any pending RDY is dropped.
      sgn_quo_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      b_mag_d   = b_mag_in;
      wr_d      = {{WIDTH{1'b0}}, a_mag};
      cnt_d     = '0;
`ifdef NR_DIV32_REMAINDER_EN
      sgn_rem_d = bus.data_operandA[WIDTH-1];
`endif
      if (bus.data_operandB == '0) begin
        state_d  = DONE;
        result_d = '0;
        exc_d    = 1'b1;
`ifdef NR_DIV32_REMAINDER_EN
        rem_d    = '0;
`endif
      end else begin
        state_d  = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          wr_d  = wr_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER-1)) state_d = FIX;
        end
        FIX: begin
          result_d = sgn_quo_q ? -quo : quo;
          exc_d    = 1'b0;
`ifdef NR_DIV32_REMAINDER_EN
          rem_d    = sgn_rem_q ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
`endif
          state_d  = DONE;
        end
        DONE: begin
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      b_mag_q   <= '0;
      cnt_q     <= '0;
      sgn_quo_q <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
`ifdef NR_DIV32_REMAINDER_EN
      sgn_rem_q <= 1'b0;
      rem_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      b_mag_q   <= b_mag_d;
      cnt_q     <= cnt_d;
      sgn_quo_q <= sgn_quo_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
`ifdef NR_DIV32_REMAINDER_EN
      sgn_rem_q <= sgn_rem_d;
      rem_q     <= rem_d;
`endif
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
`ifdef NR_DIV32_REMAINDER_EN
  assign bus.data_remainder = rem_q;
`endif
endmodule

// File: tb/tb_nr_div32.sv
// tb_nr_div32: scoreboard bench for nr_div32. The driver pushes the expected
// response (value, flags, completion edge) per start; a negedge monitor pops
// and compares on every data_resultRDY. Edge k is the k-th rising edge; an
// operation started on edge s must complete with RDY visible after s+34
// (s+1 for divide-by-zero).
module tb_nr_div32;
  logic clock = 1'b0;
  logic ctrl_reset_n = 1'b0;

  nr_div32_if bus();
  nr_div32 #(.WIDTH(32)) dut (.clock(clock), .ctrl_reset_n(ctrl_reset_n), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] rem;
    int          edge_at;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] a, b, res;
    logic        exc;
    logic [31:0] rem;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vt[11];
  int   edge_n = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   s0;

  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every RDY must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_rdy: RDY=1 after edge %0d, expected no completion", edge_n);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_rdy_edge"}, edge_n, e.edge_at);
        chk({e.name, "_result"}, bus.data_result, e.res);
        chk({e.name, "_exc"}, {31'b0, bus.data_exception}, {31'b0, e.exc});
`ifdef NR_DIV32_REMAINDER_EN
        chk({e.name, "_rem"}, bus.data_remainder, e.rem);
`endif
      end
    end
  end

  // Issue one start; optionally register its expected response.
  task automatic run(input logic [31:0] a, b, res, input logic exc,
                     input logic [31:0] rem, input int lat, input bit push,
                     input string nm);
    @(negedge clock);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_DIV = 1'b0;
    s0 = edge_n;
    if (push) begin
      exp_t e;
      e.res = res; e.exc = exc; e.rem = rem; e.edge_at = edge_n + lat; e.name = nm;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clock);
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: %0d responses outstanding, expected 0", nm, sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    // a, b, quotient, exception, remainder, latency
    vt[0]  = '{32'd7,        32'd2,        32'd3,        1'b0, 32'd1,        34};
    vt[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 34};
    vt[2]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'd0,        34};
    vt[3]  = '{32'h80000000, 32'd1,        32'h80000000, 1'b0, 32'd0,        34};
    vt[4]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 32'd2,        34};
    vt[5]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0, 32'hFFFFFFFE, 34};
    vt[6]  = '{32'd0,        32'd5,        32'd0,        1'b0, 32'd0,        34};
    vt[7]  = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0,        1'b0, 32'hFFFFFFFF, 34};
    vt[8]  = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b0, 32'h7FFFFFFF, 34};
    vt[9]  = '{32'h80000000, 32'h80000000, 32'd1,        1'b0, 32'd0,        34};
    vt[10] = '{32'h7FFFFFFF, 32'd3,        32'h2AAAAAAA, 1'b0, 32'd1,        34};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset_result", bus.data_result, 32'd0);
    chk("reset_exc", {31'b0, bus.data_exception}, 32'd0);
    chk("reset_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
`ifdef NR_DIV32_REMAINDER_EN
    chk("reset_rem", bus.data_remainder, 32'd0);
`endif
    @(negedge clock);
    ctrl_reset_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run(vt[i].a, vt[i].b, vt[i].res, vt[i].exc, vt[i].rem, vt[i].lat, 1'b1,
          $sformatf("v%0d", i));
      drain($sformatf("v%0d", i));
    end

    // Divide by zero: RDY after edge 1, values held afterwards
    run(32'd5, 32'd0, 32'd0, 1'b1, 32'd0, 1, 1'b1, "div0");
    drain("div0");
    repeat (5) @(posedge clock);
    #1;
    chk("div0_hold_result", bus.data_result, 32'd0);
    chk("div0_hold_exc", {31'b0, bus.data_exception}, 32'd1);

    // Abort-and-restart: second start on edge s+10, one RDY at s+44
    run(32'd100, 32'd7, 32'd0, 1'b0, 32'd0, 0, 1'b0, "abort");
    repeat (9) @(posedge clock);
    run(32'd9, 32'd3, 32'd3, 1'b0, 32'd0, 34, 1'b1, "restart");
    drain("restart");

    // Reset on edge s+15 of an operation: no RDY, outputs cleared
    run(32'd1000, 32'd3, 32'd0, 1'b0, 32'd0, 0, 1'b0, "rst_abort");
    repeat (14) @(posedge clock);
    @(negedge clock);
    ctrl_reset_n = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst_result", bus.data_result, 32'd0);
    chk("midrst_exc", {31'b0, bus.data_exception}, 32'd0);
    chk("midrst_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    repeat (45) @(posedge clock);
    run(32'd1000, 32'd3, 32'd333, 1'b0, 32'd1, 34, 1'b1, "after_rst");
    drain("after_rst");

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nr_div32.md
NR_DIV32 -- requirements
Module: nr_div32

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; only 32 is supported.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port ctrl_reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port ctrl_DIV  input  1  start pulse; operands are captured on the edge where it is high.
REQ-005 SHALL have ports data_operandA  input  32  signed dividend, and data_operandB  input  32  signed divisor.
REQ-006 SHALL have port data_result  output  32  signed quotient, truncated toward zero.
REQ-007 SHALL have port data_exception  output  1  divide-by-zero flag.
REQ-008 SHALL have port data_resultRDY  output  1  single-cycle completion strobe.

Function
REQ-009 SHALL be a non-restoring divider on magnitudes, using a 65-bit working register: {partial remainder[64:32] (33b signed), quotient[31:0]}.
REQ-010 SHALL implement FSM states IDLE, RUN, FIX, DONE.
- IDLE->RUN on ctrl_DIV with operandB!=0.
- IDLE->DONE on ctrl_DIV with operandB==0.
- RUN->FIX after 32 iterations.
- FIX->DONE.
- DONE->IDLE.
REQ-011 SHALL, on capture, store |A|, |B|, sign_q=A[31]^B[31] and sign_r=A[31], and load the working register with {33'b0, |A|}.
REQ-012 SHALL perform one iteration per RUN cycle.
- Shift left 1.
- Subtract |B| if remainder>=0, else add |B|.
- Set q[0]=~remainder_new[32].
- Iteration counter runs 0..31.
REQ-013 SHALL, in FIX:
- add |B| back if remainder<0;
- negate quotient if sign_q;
- negate remainder if sign_r.
REQ-014 SHALL assert data_resultRDY for exactly one cycle in DONE: start edge at cycle 0, RDY high during cycle 34.
REQ-015 SHALL, for operandB==0, set data_result=0 and data_exception=1, with data_resultRDY high during cycle 1.
REQ-016 SHALL hold data_result and data_exception stable from DONE until the next ctrl_DIV capture.
REQ-017 SHALL treat ctrl_DIV in any non-IDLE state as abort-and-restart: recapture operands, counter=0, no RDY for the aborted operation.
REQ-018 SHALL return 0x80000000 with exception=0 for A=0x80000000, B=0xFFFFFFFF (wrap, no overflow flag).
REQ-019 SHALL use 33-bit arithmetic for |x| so that |0x80000000|=2^31 is exact.

Reset
REQ-020 SHALL, on a clock edge with ctrl_reset_n=0:
- enter IDLE;
- zero the working register, counter and outputs (data_result=0, data_exception=0, data_resultRDY=0);
- abandon any operation in flight with no RDY.
REQ-021 SHALL give reset priority over a simultaneous ctrl_DIV; the start is ignored.

Configuration
REQ-022 SHALL honour macro NR_DIV32_REMAINDER_EN.
- Defined: adds port data_remainder  output  32  signed remainder with the dividend's sign, valid/held as data_result, 0 on divide-by-zero and reset.
- Undefined: the port and the FIX remainder correction are absent; quotient behaviour is identical.

Structure
REQ-023 SHALL take the FSM state enum, WIDTH=32, ITER=32 and the counter width (5) from shared package multdiv_pkg.
REQ-024 SHALL place one iteration (shift, add/sub, quotient bit) in combinational sub-module nr_div_step; nr_div32 holds the registers and FSM.

Verification
REQ-025 SHALL check A=7, B=2 at cycle 0 -> RDY at cycle 34 only, result=3, exception=0, remainder=1.
REQ-026 SHALL check A=-7 (0xFFFFFFF9), B=2 -> result=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-027 SHALL check A=5, B=0 -> cycle 1: RDY=1, exception=1, result=0; values held until next start.
REQ-028 SHALL check A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=0; A=0x80000000, B=1 -> result=0x80000000.
REQ-029 SHALL check restart: A=100, B=7 at cycle 0, then A=9, B=3 at cycle 10 -> single RDY at cycle 44, result=3.
REQ-030 SHALL check reset: ctrl_reset_n=0 at cycle 15 of an operation -> no RDY, outputs 0; a new start then completes normally.
